// File: rtl/pulse_stretch_driver_pkg.sv
// pulse_stretch_driver_pkg: state encoding and counter sizing shared by the pulse stretcher
package pulse_stretch_driver_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, GAP = 2'd2} state_t;
  function automatic int cnt_w(input int h, input int g);
    int m;
    m = h > g ? h : g;
    return m > 1 ? $clog2(m) : 1;
  endfunction
endpackage

// File: rtl/pulse_stretch_driver_if.sv
// pulse_stretch_driver_if: request/status bundle between the event source and the stretcher
interface pulse_stretch_driver_if #(parameter int PEND_MAX = 15);
  localparam int PW = $clog2(PEND_MAX + 1);
  logic          i_trig;
  logic          i_clr_ovf;
  logic          o_out;
  logic          o_busy;
  logic [PW-1:0] o_pend;
  logic          o_ovf;
  modport master (output i_trig, i_clr_ovf, input o_out, o_busy, o_pend, o_ovf);
  modport slave  (input i_trig, i_clr_ovf, output o_out, o_busy, o_pend, o_ovf);
endinterface

// File: rtl/pulse_stretch_driver.sv
// pulse_stretch_driver: stretches request strobes into fixed-width pulses with a guaranteed gap,
// queueing requests that arrive while a pulse is running
module pulse_stretch_driver
  import pulse_stretch_driver_pkg::*;
#(
  parameter int HIGH_WIDTH = 100,
  parameter int GAP_WIDTH  = 100,
  parameter int PEND_MAX   = 15,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input logic clk,
  input logic rst_n,
  pulse_stretch_driver_if.slave bus
);
  localparam int CW = cnt_w(HIGH_WIDTH, GAP_WIDTH);
  localparam int PW = $clog2(PEND_MAX + 1);
  localparam logic [CW-1:0] H_LD = CW'(HIGH_WIDTH - 1);
  localparam logic [CW-1:0] G_LD = CW'(GAP_WIDTH - 1);
  localparam logic [PW-1:0] P_MAX = PW'(PEND_MAX);
  generate
    if (HIGH_WIDTH < 1 || GAP_WIDTH < 1 || PEND_MAX < 1) begin : g_bad_param
      $error("pulse_stretch_driver: HIGH_WIDTH, GAP_WIDTH and PEND_MAX must all be >= 1");
    end
  endgenerate
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] r_pend;
  logic          r_out;
  logic          r_busy;
  logic          r_ovf;
  state_t        w_state_nx;
  logic [CW-1:0] w_cnt_nx;
  logic [PW-1:0] w_pend_nx;
  logic          w_tc;
  logic          w_last;
  logic          w_q;
  logic          w_drop;
  assign w_tc   = r_cnt == '0;
  assign w_last = r_state == GAP && w_tc;
  // the last gap cycle is excluded: a trig there is either served directly or cancels the dequeue
  assign w_q    = bus.i_trig && r_state != IDLE && !w_last;
  assign w_drop = w_q && r_pend == P_MAX;
  always_comb begin
    w_state_nx = r_state == IDLE ? (bus.i_trig ? HIGH : IDLE)
               : r_state == HIGH ? (w_tc ? GAP : HIGH)
               : !w_tc ? GAP
               : (r_pend != '0 || bus.i_trig) ? HIGH : IDLE;
    w_cnt_nx   = (w_state_nx == HIGH && r_state != HIGH) ? H_LD
               : (w_state_nx == GAP && r_state == HIGH) ? G_LD
               : w_tc ? r_cnt : r_cnt - CW'(1);
    w_pend_nx  = (w_q && !w_drop) ? r_pend + PW'(1)
               : (w_last && r_pend != '0 && !bus.i_trig) ? r_pend - PW'(1)
               : r_pend;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pend  <= '0;
      r_out   <= ACTIVE_LOW;
      r_busy  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_pend  <= w_pend_nx;
      r_out   <= (w_state_nx == HIGH) ^ ACTIVE_LOW;
      r_busy  <= w_state_nx != IDLE;
      r_ovf   <= w_drop | (r_ovf & ~bus.i_clr_ovf);
    end
  end
  assign bus.o_out  = r_out;
  assign bus.o_busy = r_busy;
  assign bus.o_pend = r_pend;
  assign bus.o_ovf  = r_ovf;
endmodule

// File: doc/pulse_stretch_driver.md
Name: pulse_stretch_driver

Overview:
- Output-side counterpart to the button edge filter. Takes single-cycle event pulses, such as filtered button edges or FSM "dispense" and "refund" strobes, and drives a physical output level such as an LED or actuator.
- Each output pulse has a guaranteed width and a guaranteed gap after it.
- Requests that arrive while a pulse is in progress are queued in a saturating counter and replayed in order.
- Instanced between the vending-machine FSM and the board output pins.

Parameters:
- HIGH_WIDTH, 100, cycles the output is held active per pulse (>=1)
- GAP_WIDTH, 100, cycles the output is held inactive after each pulse (>=1)
- PEND_MAX, 15, maximum number of queued requests (>=1)
- ACTIVE_LOW, 0, 1 = output polarity inverted (active level is 0)

Ports:
- clk  in  1  system clock; all logic on its rising edge
- rst_n  in  1  asynchronous active-low reset
- trig  in  1  single-cycle request pulse; each high cycle is one request
- clr_ovf  in  1  synchronous clear of the ovf flag
- out  out  1  stretched output level, polarity set by ACTIVE_LOW
- busy  out  1  high while in state HIGH or GAP
- pend  out  $clog2(PEND_MAX+1)  number of queued requests not yet started
- ovf  out  1  sticky flag: a request was dropped because the queue was full

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, counter=0, pend=0, ovf=0, busy=0.
  - out takes the inactive level (ACTIVE_LOW ? 1 : 0) immediately, without waiting for a clock edge.
- All outputs are registered. No combinational path from any input to any output.
- States: IDLE, HIGH, GAP.
- IDLE:
  - trig=1 -> HIGH next cycle, counter loaded for HIGH_WIDTH cycles.
  - Latency: out is active on the cycle after trig is sampled.
  - pend is always 0 in IDLE.
- HIGH:
  - out active for exactly HIGH_WIDTH cycles, then -> GAP.
- GAP:
  - out inactive for exactly GAP_WIDTH cycles.
  - On the last GAP cycle: if (pend>0 or trig=1) -> HIGH, else -> IDLE.
  - Back-to-back pulse period is exactly HIGH_WIDTH+GAP_WIDTH cycles.
- Queueing:
  - trig=1 in HIGH or GAP, except on the last GAP cycle, sets pend <= pend+1.
  - When pend=PEND_MAX the request is dropped, pend stays at PEND_MAX, and ovf <= 1.
- Dequeue:
  - Entering HIGH from GAP with pend>0 sets pend <= pend-1.
  - trig=1 on that same last GAP cycle is counted as a new request, so pend is unchanged (net 0).
  - trig=1 on the last GAP cycle with pend=0 is served directly; pend stays 0.
- ovf:
  - Cleared by clr_ovf=1.
  - If clr_ovf and a drop occur in the same cycle, set wins.
- busy = (state != IDLE), registered with the state.
- Counter:
  - Width $clog2(max(HIGH_WIDTH,GAP_WIDTH)).
  - Counts down from WIDTH-1 to 0; terminal count is 0.
  - Never wraps.
- Reset mid-operation: the pulse is aborted, the queue is flushed and ovf is cleared. The next trig after release behaves as a fresh request.
- Parameter guard: elaboration error if HIGH_WIDTH<1, GAP_WIDTH<1 or PEND_MAX<1.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE=2'd0, HIGH=2'd1, GAP=2'd2)
  - the function computing the counter width
- No sub-module. The down-counter and the pending counter stay inline; each is too small to justify its own module.

Test Plan (HIGH_WIDTH=4, GAP_WIDTH=3, PEND_MAX=2, ACTIVE_LOW=0 unless noted):
- Reset assert/release, no trig -> out=0, busy=0, pend=0, ovf=0 throughout. With ACTIVE_LOW=1, out=1 during and after reset.
- Single trig at cycle 10 -> out=1 in cycles 11..14, out=0 in 15..17, busy=1 in 11..17, busy=0 at 18.
- trig at cycles 10, 12, 13:
  - out high in 11..14, 18..21 and 25..28.
  - pend=1 at 13, 2 at 14, 1 at 18, 0 at 25.
  - busy drops at 32.
- Overflow: trig at cycle 10 then at 12, 13, 14 -> pend saturates at 2, ovf=1 from cycle 15, exactly 3 pulses output. clr_ovf at cycle 40 -> ovf=0 at 41.
- trig exactly on the last GAP cycle:
  - Single trig at cycle 10, second trig at cycle 17 -> out=1 again at 18..21, pend stays 0.
  - Repeat with pend=1 -> pend stays 1 across the dequeue.
- Async reset asserted mid-HIGH at cycle 12 with pend=1 -> out=0, busy=0, pend=0 immediately, with no clock edge needed. After release, trig produces a normal 4-cycle pulse.
